goertzel_seq: RTL and testbench
===============================

Name: goertzel_seq

Overview:
- Control sequencer for the Goertzel tone-detection datapath.
- Accepts 12-bit ADC samples through a valid/ready handshake and drives the enables that move them through the rest of the datapath: sign-extending filler, then the s1/s2 recursion, then the final power stage.
- Counts samples per analysis block, flushes the pipeline, triggers the magnitude computation and presents the result with a handshake.
- Sits between the sample source and the datapath; owns no arithmetic.

Parameters:
- BLOCK_LEN, 205, samples per Goertzel block (2..2^CNT_W).
- CNT_W, 8, sample counter width.
- PIPE_LAT, 2, cycles from the last iter_en to a settled s1/s2 (1..15).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- start  input  1  one-cycle pulse; begins a block when IDLE, ignored otherwise.
- cont  input  1  sampled in DONE on handshake: 1 = start next block automatically.
- abort  input  1  synchronous; returns to IDLE from any state next cycle.
- sample_valid  input  1  source has a sample.
- sample_ready  output  1  sequencer accepts a sample this cycle.
- fill_en  output  1  filler load enable.
- iter_en  output  1  recursion step enable.
- clr_state  output  1  clears s1/s2 registers.
- final_en  output  1  power-stage load enable.
- result_valid  output  1  power result is valid.
- result_ready  input  1  consumer takes the result.
- busy  output  1  state != IDLE.
- sample_cnt  output  CNT_W  samples accepted in the current block.

Behaviour:
- Reset (rst=0, async): state IDLE; sample_cnt=0; flush counter=0; all outputs 0.
- States: IDLE, CLEAR, ACCUM, FLUSH, FINAL, DONE.
- IDLE
  - sample_ready=0.
  - start=1 -> CLEAR.
- CLEAR (1 cycle)
  - clr_state=1, sample_cnt<=0.
  - -> ACCUM.
- ACCUM
  - sample_ready=1 (combinational from state).
  - accept = sample_valid & sample_ready.
  - fill_en = accept, same cycle (filler captures on that edge).
  - iter_en is accept delayed exactly 1 cycle (registered), so the recursion consumes the filler output.
  - On accept: sample_cnt += 1.
  - accept while sample_cnt == BLOCK_LEN-1: sample_cnt <= BLOCK_LEN, -> FLUSH.
  - Gaps in sample_valid are allowed; the counter holds.
- FLUSH
  - sample_ready=0.
  - Flush counter loads PIPE_LAT on entry and decrements each cycle.
  - The delayed iter_en for the last sample still fires in the first FLUSH cycle.
  - Counter reaches 0 -> FINAL.
  - Dwell: PIPE_LAT cycles.
- FINAL (1 cycle)
  - final_en=1.
  - -> DONE.
- DONE
  - result_valid=1, held until result_ready=1.
  - On handshake: cont=1 -> CLEAR; cont=0 -> IDLE.
  - result_valid drops the cycle after the handshake.
- Latency, fixed: the last accepted sample edge to result_valid=1 is PIPE_LAT+2 cycles.
- abort
  - Has priority over every transition.
  - Next state IDLE; sample_cnt<=0; the pending iter_en is cancelled.
  - clr_state is not pulsed.
  - abort=1 together with start in IDLE: stay IDLE.
- start is ignored outside IDLE; a start pulse in DONE is lost.
- The counter never wraps; BLOCK_LEN reaching 2^CNT_W is legal.
- All control outputs are single-cycle except sample_ready, result_valid and busy.
- sample_cnt holds BLOCK_LEN through FLUSH, FINAL and DONE.
- Mid-operation rst=0: immediate return to reset values, no flush.

Test Plan:
1. BLOCK_LEN=205, PIPE_LAT=2, sample_valid tied 1, start pulse.
   - clr_state for 1 cycle, then 205 consecutive fill_en.
   - iter_en lags fill_en by 1 cycle.
   - final_en 3 cycles after the last fill_en; result_valid 4 cycles after it.
2. Same as 1, but sample_valid toggles 1/0 every cycle.
   - Exactly 205 fill_en over 409 cycles.
   - sample_cnt steps only on accepts and ends at 205.
3. Result backpressure: result_ready=0 for 10 cycles in DONE.
   - result_valid held 1.
   - No fill_en, iter_en or final_en during the hold.
   - Single handshake when result_ready rises.
4. cont=1 at the handshake.
   - CLEAR the next cycle, then a new 205-sample block without a start pulse.
   - sample_cnt restarts at 0.
5. abort raised after 100 samples in ACCUM.
   - Next cycle IDLE, sample_ready=0, sample_cnt=0, busy=0.
   - No iter_en afterwards, no final_en.
6. rst=0 asserted mid-FLUSH.
   - All outputs 0 asynchronously.
   - After release stays IDLE until start.
   - A start in DONE produces no effect.

Source files
------------

// File: rtl/goertzel_seq_if.sv
// Valid/ready bundle between the Goertzel sequencer, its sample source and its result consumer.
interface goertzel_seq_if;
    logic sample_valid;
    logic sample_ready;
    logic result_valid;
    logic result_ready;

    modport master (
        input  sample_valid,
        input  result_ready,
        output sample_ready,
        output result_valid
    );

    modport slave (
        output sample_valid,
        output result_ready,
        input  sample_ready,
        input  result_valid
    );
endinterface

// File: rtl/goertzel_seq.sv
// Control sequencer for the Goertzel tone detector: gathers a block of samples, flushes the
// recursion pipeline, fires the power stage and hands the result over with a valid/ready pair.
module goertzel_seq #(
    parameter int BLOCK_LEN = 205,
    parameter int CNT_W     = 8,
    parameter int PIPE_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont,
    input  logic               abort,
    goertzel_seq_if.master     hs,
    output logic               fill_en,
    output logic               iter_en,
    output logic               clr_state,
    output logic               final_en,
    output logic               busy,
    output logic [CNT_W-1:0]   sample_cnt
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, FINAL, DONE} state_t;

    localparam logic [CNT_W:0] LAST_IDX   = (CNT_W+1)'(BLOCK_LEN - 1);
    localparam logic [3:0]     FLUSH_LOAD = 4'(PIPE_LAT);

    state_t         state, state_nxt;
    logic [CNT_W:0] cnt_p0;      // one spare bit so a full 2^CNT_W block never wraps
    logic [3:0]     flush_cnt;
    logic           accept_p0;
    logic           vld_p1;

    // The port cannot show 2^CNT_W, so a full-range block pins the count at all-ones.
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W:0] v);
        return v[CNT_W] ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

    always_comb begin
        state_nxt       = state;
        accept_p0       = 1'b0;
        hs.sample_ready = 1'b0;
        hs.result_valid = 1'b0;
        clr_state       = 1'b0;
        final_en        = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: begin
                clr_state = 1'b1;
                state_nxt = ACCUM;
            end
            ACCUM: begin
                hs.sample_ready = 1'b1;
                accept_p0       = hs.sample_valid;
                if (accept_p0 && cnt_p0 == LAST_IDX) state_nxt = FLUSH;
            end
            FLUSH: if (flush_cnt == 4'd1) state_nxt = FINAL;
            FINAL: begin
                final_en  = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                hs.result_valid = 1'b1;
                if (hs.result_ready) state_nxt = cont ? CLEAR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    assign fill_en    = accept_p0;
    assign iter_en    = vld_p1;
    assign busy       = (state != IDLE);
    assign sample_cnt = sat_cnt(cnt_p0);

    // p0 -> p1: filler captures on the accept edge, recursion steps one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            vld_p1    <= 1'b0;
            cnt_p0    <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= accept_p0 & ~abort;
            if (abort || state == CLEAR)
                cnt_p0 <= '0;
            else if (accept_p0)
                cnt_p0 <= cnt_p0 + (CNT_W+1)'(1);
            if (state_nxt == FLUSH && state != FLUSH)
                flush_cnt <= FLUSH_LOAD;
            else if (state == FLUSH)
                flush_cnt <= flush_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_goertzel_seq.sv
// Randomised scoreboard bench for goertzel_seq: the driver predicts every control pulse
// from the block rules, a negedge monitor pops and compares whenever the DUT asserts one.
module tb_goertzel_seq;
    localparam int BLOCK_LEN = 205;
    localparam int CNT_W     = 8;
    localparam int PIPE_LAT  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, cont, abort;
    logic             fill_en, iter_en, clr_state, final_en, busy;
    logic [CNT_W-1:0] sample_cnt;

    goertzel_seq_if hs();

    goertzel_seq #(.BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort), .hs(hs),
        .fill_en(fill_en), .iter_en(iter_en), .clr_state(clr_state), .final_en(final_en),
        .busy(busy), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // expected cycle numbers (or values) of every control event
    int q_clr[$], q_fill[$], q_fcnt[$], q_iter[$], q_final[$], q_res[$], q_rlen[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input string nm, input int act, ref int q[$]);
        int e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: unexpected event, got %0d, required none (cycle %0d)", nm, act, cyc);
        end else begin
            e = q.pop_front();
            check(nm, act, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_fill_en"}, fill_en, 0);
        check({tag, "_iter_en"}, iter_en, 0);
        check({tag, "_clr_state"}, clr_state, 0);
        check({tag, "_final_en"}, final_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sample_ready"}, hs.sample_ready, 0);
        check({tag, "_result_valid"}, hs.result_valid, 0);
        check({tag, "_sample_cnt"}, sample_cnt, 0);
    endtask

    // mode 0: valid tied high, 1: toggling, 2: random
    task automatic run_block(input int mode, input int hold, input bit cont_v,
                             input bit use_start, input bit lose_start, input bit rst_in_flush);
        int k, n, last;
        bit v;
        if (use_start) begin
            k = cyc;
            start = 1'b1;
            q_clr.push_back(k + 1);
            tick();
            start = 1'b0;
        end else begin
            k = cyc - 1;
            q_clr.push_back(k + 1);
        end
        hs.sample_valid = 1'($urandom_range(0, 1));
        tick();
        n = 0;
        last = 0;
        while (n < BLOCK_LEN) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ((cyc - (k + 2)) % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            hs.sample_valid = v;
            if (v) begin
                q_fill.push_back(cyc);
                q_fcnt.push_back(n);
                q_iter.push_back(cyc + 1);
                n++;
                last = cyc;
            end
            tick();
        end
        hs.sample_valid = 1'($urandom_range(0, 1));
        if (rst_in_flush) begin
            void'(q_iter.pop_back());
            #2;
            rst = 1'b0;
            #1;
            check_quiet("rst_async");
            repeat (3) tick();
            rst = 1'b1;
            repeat (5) begin
                tick();
                check("post_rst_busy", busy, 0);
                check("post_rst_ready", hs.sample_ready, 0);
            end
            return;
        end
        q_final.push_back(last + PIPE_LAT + 1);
        q_res.push_back(last + PIPE_LAT + 2);
        q_rlen.push_back(hold + 1);
        while (cyc < last + PIPE_LAT + 2) tick();
        for (int h = 0; h <= hold; h++) begin
            hs.result_ready = (h == hold);
            cont = (h == hold) ? cont_v : 1'b0;
            start = lose_start && (h == 0);
            tick();
        end
        hs.result_ready = 1'b0;
        cont = 1'b0;
        start = 1'b0;
        if (!cont_v) check("idle_after_handshake_busy", busy, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a control event
    initial begin : monitor
        bit rv_prev;
        int rv_run;
        rv_prev = 1'b0;
        rv_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (clr_state) expect_evt("clr_state", cyc, q_clr);
                if (fill_en) begin
                    expect_evt("fill_en", cyc, q_fill);
                    expect_evt("sample_cnt_at_fill", int'(sample_cnt), q_fcnt);
                end
                if (iter_en) expect_evt("iter_en", cyc, q_iter);
                if (final_en) expect_evt("final_en", cyc, q_final);
                if (hs.result_valid && !rv_prev) begin
                    expect_evt("result_valid_rise", cyc, q_res);
                    rv_run = 0;
                end
                if (hs.result_valid) rv_run++;
                if (!hs.result_valid && rv_prev) expect_evt("result_valid_len", rv_run, q_rlen);
                if (hs.result_valid && hs.result_ready) begin
                    check("cnt_at_handshake", sample_cnt, BLOCK_LEN);
                    check("busy_in_done", busy, 1);
                end
            end
            rv_prev = hs.result_valid;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, got unfinished run, required completion");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int a;
        rst = 1'b0;
        start = 1'b0;
        cont = 1'b0;
        abort = 1'b0;
        hs.sample_valid = 1'b0;
        hs.result_ready = 1'b0;
        #12;
        check_quiet("reset");
        tick();
        rst = 1'b1;
        repeat (3) begin
            hs.sample_valid = 1'($urandom_range(0, 1));
            tick();
        end

        run_block(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);               // back-to-back samples
        repeat (3) tick();
        run_block(1, 0, 1'b0, 1'b1, 1'b0, 1'b0);               // toggling valid
        repeat (2) tick();
        run_block(0, 10, 1'b0, 1'b1, 1'b0, 1'b0);              // result backpressure
        tick();
        run_block(2, $urandom_range(0, 6), 1'b1, 1'b1, 1'b0, 1'b0); // continue into next block
        run_block(2, 3, 1'b0, 1'b0, 1'b1, 1'b0);               // no start, start lost in DONE
        repeat (3) tick();

        // abort after 100 samples; the sample accepted in the abort cycle never iterates
        start = 1'b1;
        q_clr.push_back(cyc + 1);
        tick();
        start = 1'b0;
        tick();
        for (int n = 0; n < 100; n++) begin
            hs.sample_valid = 1'b1;
            q_fill.push_back(cyc);
            q_fcnt.push_back(n);
            q_iter.push_back(cyc + 1);
            tick();
        end
        a = cyc;
        abort = 1'b1;
        q_fill.push_back(a);
        q_fcnt.push_back(100);
        tick();
        abort = 1'b0;
        check("abort_ready", hs.sample_ready, 0);
        check("abort_cnt", sample_cnt, 0);
        check("abort_busy", busy, 0);
        repeat (6) tick();
        hs.sample_valid = 1'b0;

        // abort wins over start in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("abort_start_busy", busy, 0);
        tick();
        check("abort_start_busy2", busy, 0);

        run_block(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);               // reset during FLUSH
        run_block(2, 1, 1'b0, 1'b1, 1'b0, 1'b0);               // recovers after reset
        repeat (4) tick();

        check("left_clr", q_clr.size(), 0);
        check("left_fill", q_fill.size(), 0);
        check("left_iter", q_iter.size(), 0);
        check("left_final", q_final.size(), 0);
        check("left_res", q_res.size(), 0);
        check("left_rlen", q_rlen.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
